// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for fifo_input_arbiter
//
// Purpose: arbiter state encoding, requester-count ceiling and a behavioural
//          round-robin pick usable by any block that needs the same ordering.
// Ports:   none (package).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_MAX = 16;

  // First requester with req_vec set, scanning ptr+1, ptr+2, ... modulo num_req.
  // Returns ptr unchanged when nothing is requesting.
  function automatic int unsigned rr_next(input logic [NUM_REQ_MAX-1:0] req_vec,
                                          input int unsigned ptr,
                                          input int unsigned num_req);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ_MAX; k++) begin
      idx = (ptr + k) % num_req;
      if (!found && (k <= num_req) && req_vec[idx[3:0]]) begin
        found   = 1'b1;
        rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick (rotate, find-first, unrotate)
//
// Purpose: select the first set bit of req starting just after ptr, wrapping.
// Ports:
//   req  in  N  request vector
//   ptr  in  W  index of the previous winner; scanning starts at ptr+1
//   any  out 1  at least one request present
//   idx  out W  winning index (meaningful only when any=1)
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    off;
  int unsigned    sum;

  always_comb begin
    // rot[j] is req[(ptr+1+j) mod N]; a shift of exactly N (ptr=N-1) yields req itself.
    dbl = {req, req} >> (int'(ptr) + 1);
    rot = dbl[N-1:0];
    off = 0;
    // Descending loop so the lowest set offset is the one that sticks.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = unsigned'(j);
      end
    end
    sum = 32'(ptr) + 32'd1 + off;
    if (sum >= unsigned'(N)) begin
      sum = sum - unsigned'(N);
    end
    idx = sum[W-1:0];
    any = |req;
  end

endmodule

// File: rtl/fifo_input_arbiter.sv
// rtl/fifo_input_arbiter.sv - burst-locked round-robin arbiter in front of a ready/valid FIFO input
//
// Purpose: shares one FIFO input port among NUM_REQ requesters. A grant is held
//          until the granted requester hands over a beat with last=1. New grants
//          are withheld while input_almost_full is high.
// Optional: define KANAGAWA_FIFO_ARB_STATS_EN to add grant_count (32-bit
//           saturating per-requester grant counters).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/last/data per-requester stream in (data i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready          per-requester ready
//   out_valid/data/src stream to the FIFO input, out_src = granted requester
//   out_ready          FIFO input ready
//   input_almost_full  FIFO almost-full flag, sampled only while arbitrating
//   busy               high while a burst owns the FIFO
//   grant_count        (optional) NUM_REQ x 32-bit grant counters
module fifo_input_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_WIDTH-1:0]          out_src,
  input  logic                          out_ready,
  input  logic                          input_almost_full,
  output logic                          busy
`ifdef KANAGAWA_FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         grant_count
`endif
);

  arb_state_e           state, state_nxt;
  logic [SRC_WIDTH-1:0] sel, sel_nxt;
  logic [SRC_WIDTH-1:0] ptr, ptr_nxt;
  logic                 pick_any;
  logic [SRC_WIDTH-1:0] pick_idx;
  logic                 grant;

  rr_priority_pick #(
    .N (NUM_REQ),
    .W (SRC_WIDTH)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Arbitration happens only from IDLE; a burst in flight always finishes even
  // if the FIFO becomes almost full, relying on its headroom.
  assign grant = (state == IDLE) && !input_almost_full && pick_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= SRC_WIDTH'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    out_valid = 1'b0;
    out_data  = '0;
    out_src   = sel;
    req_ready = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          sel_nxt   = pick_idx;
          state_nxt = BURST;
        end
      end
      BURST: begin
        busy           = 1'b1;
        out_valid      = req_valid[sel];
        out_data       = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
        // Ready depends only on the grant and out_ready, never on req_valid.
        req_ready[sel] = out_ready;
        if (out_valid && out_ready && req_last[sel]) begin
          state_nxt = IDLE;
          ptr_nxt   = sel;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef KANAGAWA_FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant && (pick_idx == SRC_WIDTH'(i)) && (grant_count[i*32 +: 32] != 32'hFFFF_FFFF)) begin
          grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_input_arbiter.sv
// tb/tb_fifo_input_arbiter.sv - self-checking bench for fifo_input_arbiter
module tb_fifo_input_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic            input_almost_full;
  logic            busy;
`ifdef KANAGAWA_FIFO_ARB_STATS_EN
  logic [N*32-1:0] grant_count;
`endif

  always #5 clk = ~clk;

  fifo_input_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .SRC_WIDTH  (SW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_last          (req_last),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_src           (out_src),
    .out_ready         (out_ready),
    .input_almost_full (input_almost_full),
    .busy              (busy)
`ifdef KANAGAWA_FIFO_ARB_STATS_EN
    ,
    .grant_count       (grant_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Beats waiting to be offered by each requester, and the copy the FIFO side
  // expects to see, both as {last, data}.
  logic [DW:0] txq [N][$];
  logic [DW:0] sb  [N][$];
  bit          hold [N];
  int          valid_pct = 100;
  bit          rdy_rand  = 1'b0;
  bit          af        = 1'b0;

  bit            obs_valid, obs_hs, obs_busy;
  int            obs_src;
  logic [DW-1:0] obs_data;
  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_reqv;
  int            obs_req_hs;
  int            obs_nhs;

  task automatic push_burst(input int src, input int len);
    logic [DW:0] beat;
    for (int b = 0; b < len; b++) begin
      beat = {(b == len - 1), DW'($urandom)};
      txq[src].push_back(beat);
      sb[src].push_back(beat);
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      sb[i].delete();
      hold[i] = 1'b0;
    end
  endtask

  // One clock: requesters present their head beat (holding valid until accepted),
  // outputs are sampled at negedge+1, accepted beats retire after the posedge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && txq[i].size() > 0 && $urandom_range(99) < valid_pct) hold[i] = 1'b1;
      req_valid[i] = hold[i];
      if (hold[i]) begin
        req_data[i*DW +: DW] = txq[i][0][DW-1:0];
        req_last[i]          = txq[i][0][DW];
      end else begin
        req_data[i*DW +: DW] = DW'($urandom);
        req_last[i]          = 1'($urandom);
      end
    end
    out_ready         = rdy_rand ? 1'($urandom) : 1'b1;
    input_almost_full = af;
    #1;
    obs_valid  = out_valid;
    obs_hs     = out_valid && out_ready;
    obs_busy   = busy;
    obs_src    = int'(out_src);
    obs_data   = out_data;
    obs_ready  = req_ready;
    obs_reqv   = req_valid;
    obs_req_hs = -1;
    obs_nhs    = 0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        obs_req_hs = i;
        obs_nhs++;
      end
    end
    @(posedge clk);
    if (obs_req_hs >= 0) begin
      void'(txq[obs_req_hs].pop_front());
      hold[obs_req_hs] = 1'b0;
    end
  endtask

  function automatic int rr_ref(input int last, input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    apply_reset(2);
    tick();
    vectors++; if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", obs_valid); end
    vectors++; if (obs_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", obs_ready); end
    vectors++; if (obs_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", obs_busy); end
    vectors++; if (obs_src != 0) begin miscompares++; $display("FAIL reset_out_src got %0d want 0", obs_src); end
    vectors++; if (obs_data !== '0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", obs_data); end
  endtask

  task automatic test_round_robin();
    logic [DW:0] exp;
    for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) push_burst(i, 1);
    for (int k = 0; k < 24; k++) begin
      tick();
      vectors++;
      if (k % 2 == 0) begin
        if (obs_busy || obs_valid) begin miscompares++; $display("FAIL rr_idle cycle %0d got busy=%0b valid=%0b want 0 0", k, obs_busy, obs_valid); end
      end else if (!obs_hs || obs_src != (k / 2) % N) begin
        miscompares++; $display("FAIL rr_grant cycle %0d got hs=%0b src=%0d want 1 %0d", k, obs_hs, obs_src, (k / 2) % N);
      end else begin
        exp = sb[obs_src].pop_front();
        vectors++;
        if (obs_data !== exp[DW-1:0]) begin miscompares++; $display("FAIL rr_data got %h want %h", obs_data, exp[DW-1:0]); end
      end
    end
  endtask

  task automatic test_burst_lock();
    logic [DW:0] exp;
    push_burst(1, 5);
    push_burst(2, 1);
    tick();
    vectors++; if (obs_busy) begin miscompares++; $display("FAIL lock_arb got busy=1 want 0"); end
    for (int b = 0; b < 5; b++) begin
      tick();
      vectors++;
      if (!obs_hs || obs_src != 1 || obs_ready[2]) begin
        miscompares++; $display("FAIL lock_beat %0d got hs=%0b src=%0d ready2=%0b want 1 1 0", b, obs_hs, obs_src, obs_ready[2]);
      end else begin
        exp = sb[1].pop_front();
        vectors++;
        if (obs_data !== exp[DW-1:0]) begin miscompares++; $display("FAIL lock_data got %h want %h", obs_data, exp[DW-1:0]); end
      end
    end
    tick();
    vectors++; if (obs_busy || obs_valid) begin miscompares++; $display("FAIL lock_gap got busy=%0b valid=%0b want 0 0", obs_busy, obs_valid); end
    tick();
    vectors++;
    if (!obs_hs || obs_src != 2) begin miscompares++; $display("FAIL lock_next got hs=%0b src=%0d want 1 2", obs_hs, obs_src); end
    else void'(sb[2].pop_front());
  endtask

  task automatic test_almost_full();
    af = 1'b1;
    push_burst(0, 1);
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++; if (obs_valid || obs_busy) begin miscompares++; $display("FAIL af_hold cycle %0d got valid=%0b busy=%0b want 0 0", c, obs_valid, obs_busy); end
    end
    af = 1'b0;
    tick();
    vectors++; if (obs_busy) begin miscompares++; $display("FAIL af_release got busy=1 want 0"); end
    tick();
    vectors++;
    if (!obs_busy || !obs_hs || obs_src != 0) begin miscompares++; $display("FAIL af_grant got busy=%0b hs=%0b src=%0d want 1 1 0", obs_busy, obs_hs, obs_src); end
    else void'(sb[0].pop_front());
  endtask

  task automatic test_af_mid_burst();
    logic [DW:0] exp;
    push_burst(2, 4);
    push_burst(3, 1);
    tick();
    for (int b = 0; b < 4; b++) begin
      if (b == 1) af = 1'b1;
      tick();
      vectors++;
      if (!obs_hs || obs_src != 2) begin
        miscompares++; $display("FAIL afmid_beat %0d got hs=%0b src=%0d want 1 2", b, obs_hs, obs_src);
      end else begin
        exp = sb[2].pop_front();
        vectors++;
        if (obs_data !== exp[DW-1:0] || exp[DW] != (b == 3)) begin miscompares++; $display("FAIL afmid_data got %h want %h", obs_data, exp[DW-1:0]); end
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++; if (obs_busy || obs_valid) begin miscompares++; $display("FAIL afmid_idle got busy=%0b valid=%0b want 0 0", obs_busy, obs_valid); end
    end
    af = 1'b0;
    tick();
    tick();
    vectors++;
    if (!obs_hs || obs_src != 3) begin miscompares++; $display("FAIL afmid_resume got hs=%0b src=%0d want 1 3", obs_hs, obs_src); end
    else void'(sb[3].pop_front());
  endtask

  task automatic test_random();
    logic [DW:0] exp;
    int total = 0, delivered = 0, cycles = 0;
    int owner = -1, last_win = N - 1;
    bit stalled = 1'b0;
    apply_reset(1);
    rdy_rand  = 1'b1;
    valid_pct = 70;
    while (total < 10000) begin
      int len;
      len = $urandom_range(8, 1);
      push_burst($urandom_range(N - 1), len);
      total += len;
    end
    while (delivered < total && cycles < 80000) begin
      tick();
      cycles++;
      vectors++;
      if (obs_busy !== (owner >= 0)) begin miscompares++; $display("FAIL rnd_busy cycle %0d got %0b want %0b", cycles, obs_busy, owner >= 0); end
      if (stalled && !obs_valid) begin miscompares++; $display("FAIL rnd_valid_drop cycle %0d got 0 want 1", cycles); end
      stalled = obs_valid && !obs_hs;
      if (owner < 0) begin
        if (obs_valid || obs_ready != '0) begin miscompares++; $display("FAIL rnd_idle got valid=%0b ready=%b want 0 0000", obs_valid, obs_ready); end
        if (obs_reqv != '0) owner = rr_ref(last_win, obs_reqv);
      end else begin
        if (obs_src != owner) begin miscompares++; $display("FAIL rnd_src got %0d want %0d", obs_src, owner); end
        if (obs_nhs != int'(obs_hs) || (obs_hs && obs_req_hs != owner)) begin
          miscompares++; $display("FAIL rnd_handshake got nreq=%0d req=%0d out=%0b want %0d %0d", obs_nhs, obs_req_hs, obs_hs, int'(obs_hs), owner);
        end
        if (obs_hs) begin
          if (sb[owner].size() == 0) begin
            miscompares++; $display("FAIL rnd_extra_beat src %0d got beat want none", owner);
            break;
          end
          exp = sb[owner].pop_front();
          delivered++;
          vectors++;
          if (obs_data !== exp[DW-1:0]) begin miscompares++; $display("FAIL rnd_data src %0d got %h want %h", owner, obs_data, exp[DW-1:0]); end
          if (exp[DW]) begin
            last_win = owner;
            owner    = -1;
          end
        end
      end
    end
    vectors++;
    if (delivered != total) begin miscompares++; $display("FAIL rnd_total got %0d want %0d", delivered, total); end
    rdy_rand  = 1'b0;
    valid_pct = 100;
  endtask

  task automatic test_reset_mid_burst();
    push_burst(3, 4);
    tick();
    tick();
    vectors++; if (!obs_hs || obs_src != 3) begin miscompares++; $display("FAIL rstmid_start got hs=%0b src=%0d want 1 3", obs_hs, obs_src); end
    apply_reset(1);
    push_burst(1, 1);
    push_burst(2, 1);
    push_burst(3, 4);
    tick();
    vectors++;
    if (obs_busy || obs_valid || obs_ready != '0) begin
      miscompares++; $display("FAIL rstmid_idle got busy=%0b valid=%0b ready=%b want 0 0 0000", obs_busy, obs_valid, obs_ready);
    end
    tick();
    vectors++; if (!obs_hs || obs_src != 1) begin miscompares++; $display("FAIL rstmid_first got hs=%0b src=%0d want 1 1", obs_hs, obs_src); end
  endtask

  initial begin
    rst               = 1'b1;
    req_valid         = '0;
    req_last          = '0;
    req_data          = '0;
    out_ready         = 1'b0;
    input_almost_full = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_almost_full();
    test_af_mid_burst();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
